// File: rtl/mem_access_ctrl.sv
// Request/response front-end for a single-port synchronous RAM with 1-cycle read latency.
// Optionally zero-fills the RAM after reset, then serves one read or write at a time.
module mem_access_ctrl #(
    parameter int A       = 8,
    parameter int D       = 8,
    parameter int R       = 256,
    parameter bit INIT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [A-1:0] req_addr,
    input  logic [D-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [D-1:0] rsp_rdata,
    output logic         mem_ce,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_data,
    input  logic [D-1:0] mem_q,
    output logic         init_done
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RSP   = 3'd4
    } state_t;

    localparam state_t       RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;
    localparam logic [A-1:0] LAST_ADDR = A'(R - 1);
    localparam logic [A-1:0] ADDR_ONE  = A'(1);

    state_t       state_q,     state_d;
    logic         mem_ce_q,    mem_ce_d;
    logic         mem_we_q,    mem_we_d;
    logic [A-1:0] mem_addr_q,  mem_addr_d;
    logic [D-1:0] mem_data_q,  mem_data_d;
    logic         req_ready_q, req_ready_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [D-1:0] rsp_rdata_q, rsp_rdata_d;
    logic         init_done_q, init_done_d;

    // Next-state and next-output decode; every output is computed one cycle ahead and registered.
    always_comb begin
        state_d     = state_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                // mem_ce_q low means the sweep has not issued address 0 yet
                if (mem_ce_q && (mem_addr_q == LAST_ADDR)) begin
                    state_d     = ST_IDLE;
                    mem_ce_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    init_done_d = 1'b1;
                    req_ready_d = 1'b1;
                end else begin
                    mem_ce_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_data_d  = {D{1'b0}};
                    mem_addr_d  = mem_ce_q ? (mem_addr_q + ADDR_ONE) : {A{1'b0}};
                end
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    state_d     = ST_ISSUE;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = req_we;
                    mem_addr_d  = req_addr;
                    mem_data_d  = req_wdata;
                    req_ready_d = 1'b0;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                mem_ce_d = 1'b0;
                mem_we_d = 1'b0;
                if (mem_we_q) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    state_d     = ST_CAPT;
                end
            end
            ST_CAPT: begin
                rsp_rdata_d = mem_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RSP;
                end
            end
            default: begin
                state_d     = RST_STATE;
                mem_ce_d    = 1'b0;
                mem_we_d    = 1'b0;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {A{1'b0}};
            mem_data_q  <= {D{1'b0}};
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {D{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule
